// File: rtl/noc_packet_tx_if.sv
// Shared NoC flit types and the flit/enable/ack node port used between
// network interfaces and routers.
package noc_pkg;
    localparam int PAYLOAD_W = 32;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
    } addr_t;

    typedef enum logic [1:0] {
        FT_IDLE   = 2'd0,
        FT_HEADER = 2'd1,
        FT_DATA   = 2'd2,
        FT_TAIL   = 2'd3
    } flit_type_t;

    typedef struct packed {
        addr_t       dst_addr;
        addr_t       src_addr;
        logic [15:0] rsvd;
    } flit_hdr_t;

    typedef struct packed {
        flit_type_t             flit_type;
        logic [PAYLOAD_W-1:0]   payload;
    } flit_t;
endpackage

interface node_port;
    noc_pkg::flit_t flit;
    logic           enable;
    logic           ack;

    modport up   (output flit, output enable, input ack);
    modport down (input flit, input enable, output ack);
endinterface

// File: rtl/noc_packet_tx.sv
// Source network interface: buffers a whole packet's payload, then emits
// HEADER, DATA..., TAIL on a router port without bubbles.
module noc_packet_tx
    import noc_pkg::*;
#(
    parameter int X       = 1,
    parameter int Y       = 1,
    parameter int MAX_LEN = 8,
    parameter int DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  addr_t                         cmd_dst,
    input  logic [$clog2(MAX_LEN+1)-1:0]  cmd_len,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [PAYLOAD_W-1:0]          wr_data,
    node_port.up                          tx,
    output logic                          busy,
    output logic                          pkt_done,
    output logic                          cmd_err
);

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [LW-1:0] MAX_LEN_C  = LW'(MAX_LEN);
    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR_C = PW'(DEPTH - 1);

    if (DEPTH < MAX_LEN) begin : g_depth_chk
        $error("noc_packet_tx: DEPTH must be >= MAX_LEN");
    end
    if (MAX_LEN < 1 || X < 0 || Y < 0) begin : g_param_chk
        $error("noc_packet_tx: MAX_LEN must be >= 1 and coordinates non-negative");
    end

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_DATA = 2'd1,
        ST_SEND_HDR  = 2'd2,
        ST_SEND_BODY = 2'd3
    } state_t;

    state_t               state_r;
    addr_t                dst_r;
    logic [LW-1:0]        len_r;
    logic [LW-1:0]        rem_r;
    logic                 cmd_ready_r;
    logic                 busy_r;
    logic                 enable_r;
    logic                 pkt_done_r;
    logic                 cmd_err_r;
    logic                 wr_ready_r;
    logic [PAYLOAD_W-1:0] mem_r [DEPTH];
    logic [PW-1:0]        wr_ptr_r;
    logic [PW-1:0]        rd_ptr_r;
    logic [CW-1:0]        count_r;
    logic [CW-1:0]        count_nxt_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 len_bad_s;
    flit_hdr_t            hdr_s;
    flit_t                flit_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        ptr_inc = (p == LAST_PTR_C) ? {PW{1'b0}} : p + PW'(1);
    endfunction

    assign push_s    = wr_valid && wr_ready_r;
    assign pop_s     = (state_r == ST_SEND_BODY) && tx.ack;
    assign len_bad_s = (cmd_len == {LW{1'b0}}) || (cmd_len > MAX_LEN_C);

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // FIFO pointers, count and the full flag (full stays full through a pop cycle).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            count_r    <= {CW{1'b0}};
            wr_ready_r <= 1'b1;
        end else begin
            if (push_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
            if (pop_s)  rd_ptr_r <= ptr_inc(rd_ptr_r);
            count_r    <= count_nxt_s;
            wr_ready_r <= (count_nxt_s < DEPTH_C);
        end
    end

    // Payload storage.
    always_ff @(posedge clk) begin
        if (push_s) mem_r[wr_ptr_r] <= wr_data;
    end

    // Packet sequencer with registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            dst_r       <= '0;
            len_r       <= {LW{1'b0}};
            rem_r       <= {LW{1'b0}};
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            enable_r    <= 1'b0;
            pkt_done_r  <= 1'b0;
            cmd_err_r   <= 1'b0;
        end else begin
            pkt_done_r <= 1'b0;
            cmd_err_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        dst_r <= cmd_dst;
                        len_r <= cmd_len;
                        if (len_bad_s) begin
                            cmd_err_r <= 1'b1;
                        end else begin
                            state_r     <= ST_WAIT_DATA;
                            cmd_ready_r <= 1'b0;
                            busy_r      <= 1'b1;
                        end
                    end
                end
                ST_WAIT_DATA: begin
                    if (count_r >= CW'(len_r)) begin
                        state_r  <= ST_SEND_HDR;
                        enable_r <= 1'b1;
                    end
                end
                ST_SEND_HDR: begin
                    if (tx.ack) begin
                        rem_r   <= len_r;
                        state_r <= ST_SEND_BODY;
                    end
                end
                ST_SEND_BODY: begin
                    if (tx.ack) begin
                        rem_r <= rem_r - LW'(1);
                        if (rem_r == LW'(1)) begin
                            state_r     <= ST_IDLE;
                            enable_r    <= 1'b0;
                            busy_r      <= 1'b0;
                            cmd_ready_r <= 1'b1;
                            pkt_done_r  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    enable_r    <= 1'b0;
                    busy_r      <= 1'b0;
                    cmd_ready_r <= 1'b1;
                end
            endcase
        end
    end

    // Flit word is a pure function of registers and the FIFO head, never of ack.
    always_comb begin
        hdr_s          = '0;
        hdr_s.dst_addr = dst_r;
        flit_s         = '0;
        case (state_r)
            ST_SEND_HDR: begin
                flit_s.flit_type = FT_HEADER;
                flit_s.payload   = hdr_s;
            end
            ST_SEND_BODY: begin
                flit_s.flit_type = (rem_r == LW'(1)) ? FT_TAIL : FT_DATA;
                flit_s.payload   = mem_r[rd_ptr_r];
            end
            default: begin
                flit_s = '0;
            end
        endcase
    end

    assign tx.flit   = flit_s;
    assign tx.enable = enable_r;
    assign cmd_ready = cmd_ready_r;
    assign wr_ready  = wr_ready_r;
    assign busy      = busy_r;
    assign pkt_done  = pkt_done_r;
    assign cmd_err   = cmd_err_r;

endmodule
